// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: merges ALU and load-unit results onto the single register-file write port
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   alu_valid/alu_rd/alu_data   fixed-latency ALU result, highest priority
//   alu_stall                   ALU result not consumed this cycle; upstream holds it
//   ld_valid/ld_ready           load-unit handshake into the load FIFO
//   ld_rd/ld_data               load destination and data
//   regWrite/rd/write_data      registered write port to the register file
//   pending                     FIFO occupancy, killed entries included
//
// Optional feature macro: WB_ANTISTARVE_EN
//   When defined, a FIFO head that has waited STARVE_LIMIT cycles stalls the
//   ALU for one cycle so the head can drain. When undefined, alu_stall is 0.
module regfile_writeback_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    output logic                     alu_stall,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [31:0]              ld_data,
    output logic                     regWrite,
    output logic [4:0]               rd,
    output logic [31:0]              write_data,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (STARVE_LIMIT < 1) begin : g_limit_chk
        $error("STARVE_LIMIT must be at least 1");
    end

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [4:0]    frd_q   [DEPTH];
    logic [4:0]    frd_d   [DEPTH];
    logic [31:0]   fdata_q [DEPTH];
    logic [31:0]   fdata_d [DEPTH];
    logic          fkill_q [DEPTH];
    logic          fkill_d [DEPTH];
    logic          regwrite_d;
    logic [4:0]    rd_d;
    logic [31:0]   write_data_d;
    logic          alu_take, pop, push, kill_en, head_live;

    // Ready depends on registered occupancy only, so a same-cycle pop never
    // makes a full FIFO ready.
    assign ld_ready  = rst_n && (cnt_q != (AW+1)'(DEPTH));
    assign push      = ld_valid && ld_ready;
    assign alu_take  = alu_valid && !alu_stall;
    assign pop       = !alu_take && (cnt_q != '0);
    assign kill_en   = alu_take && (alu_rd != 5'd0);
    assign head_live = !fkill_q[rptr_q] && (frd_q[rptr_q] != 5'd0);
    assign pending   = cnt_q;

`ifdef WB_ANTISTARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;

    assign alu_stall = starve_q >= SW'(STARVE_LIMIT);
    // Counts only while the head waits; the forced pop under stall clears it,
    // so it never passes STARVE_LIMIT.
    assign starve_d  = (cnt_q == '0 || pop) ? '0 : starve_q + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`else
    assign alu_stall = 1'b0;
`endif

    always_comb begin
        frd_d   = frd_q;
        fdata_d = fdata_q;
        fkill_d = fkill_q;
        // A consumed ALU write makes every older queued load to the same rd stale.
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && frd_q[i] == alu_rd) fkill_d[i] = 1'b1;
        end
        // A load accepted alongside the ALU write is older, so it enters pre-killed.
        if (push) begin
            frd_d[wptr_q]   = ld_rd;
            fdata_d[wptr_q] = ld_data;
            fkill_d[wptr_q] = kill_en && (ld_rd == alu_rd);
        end
        wptr_d       = wptr_q + AW'(push);
        rptr_d       = rptr_q + AW'(pop);
        cnt_d        = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        regwrite_d   = alu_take ? (alu_rd != 5'd0) : (pop && head_live);
        rd_d         = !regwrite_d ? rd : alu_take ? alu_rd : frd_q[rptr_q];
        write_data_d = !regwrite_d ? write_data : alu_take ? alu_data : fdata_q[rptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            regWrite   <= 1'b0;
            rd         <= 5'd0;
            write_data <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                frd_q[i]   <= 5'd0;
                fdata_q[i] <= 32'd0;
                fkill_q[i] <= 1'b0;
            end
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            regWrite   <= regwrite_d;
            rd         <= rd_d;
            write_data <= write_data_d;
            frd_q      <= frd_d;
            fdata_q    <= fdata_d;
            fkill_q    <= fkill_d;
        end
    end
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb_regfile_writeback_arbiter: directed self-checking bench for the writeback arbiter
module tb_regfile_writeback_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        alu_stall;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = 5'd0;
    logic [31:0] ld_data = 32'd0;
    logic        regWrite;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [2:0]  pending;
    int          total = 0;
    int          bad = 0;

    regfile_writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .regWrite(regWrite), .rd(rd), .write_data(write_data), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
        chk({tag, ".we"}, 32'(regWrite), 32'(we));
        if (we) begin
            chk({tag, ".rd"}, 32'(rd), 32'(r));
            chk({tag, ".data"}, write_data, d);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid = lv; ld_rd = lr; ld_data = ldd;
    endtask

    initial begin
        #2;
        chk("rst.we", 32'(regWrite), 32'd0);
        chk("rst.rd", 32'(rd), 32'd0);
        chk("rst.data", write_data, 32'd0);
        chk("rst.pending", 32'(pending), 32'd0);
        chk("rst.ready", 32'(ld_ready), 32'd0);
        chk("rst.stall", 32'(alu_stall), 32'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("post_rst.ready", 32'(ld_ready), 32'd1);
        wr("post_rst", 1'b0, 5'd0, 32'd0);

        // ALU only, including an x0 destination
        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0); tick();
        wr("alu5", 1'b1, 5'd5, 32'hDEADBEEF);
        drive(1, 5'd0, 32'h12345678, 0, 0, 0); tick();
        wr("alu_x0", 1'b0, 5'd0, 32'd0);
        drive(0, 0, 0, 0, 0, 0); tick();
        wr("idle", 1'b0, 5'd0, 32'd0);

        // Fill the FIFO while the ALU writes every cycle
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5'd10, 32'hA0 + 32'(i), 1, 5'(i), 32'h100 + 32'(i)); tick();
            wr("fill.alu", 1'b1, 5'd10, 32'hA0 + 32'(i));
            chk("fill.pending", 32'(pending), 32'(i));
        end
        chk("full.ready", 32'(ld_ready), 32'd0);
        chk("full.stall", 32'(alu_stall), 32'd0);
        drive(1, 5'd10, 32'hA5, 1, 5'd31, 32'hBAD); tick();
        chk("full.ignored_push", 32'(pending), 32'd4);
        chk("full.ready2", 32'(ld_ready), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            wr("drain", 1'b1, 5'(i), 32'h100 + 32'(i));
            chk("drain.pending", 32'(pending), 32'(4 - i));
        end
        tick();
        wr("drain.done", 1'b0, 5'd0, 32'd0);

        // Reset mid-drain with three entries still queued
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5'd11, 32'hB0, 1, 5'(i + 12), 32'h200 + 32'(i)); tick();
        end
        drive(0, 0, 0, 0, 0, 0); tick();
        wr("mid_drain", 1'b1, 5'd13, 32'h201);
        chk("mid_drain.pending", 32'(pending), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.we", 32'(regWrite), 32'd0);
        chk("async_rst.pending", 32'(pending), 32'd0);
        chk("async_rst.ready", 32'(ld_ready), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("rerst.ready", 32'(ld_ready), 32'd1);
        wr("rerst.no_write", 1'b0, 5'd0, 32'd0);
        tick();
        wr("rerst.no_write2", 1'b0, 5'd0, 32'd0);
        chk("rerst.pending", 32'(pending), 32'd0);

        // WAW kill of a queued stale load
        drive(1, 5'd3, 32'h33, 1, 5'd7, 32'h11); tick();
        wr("waw.alu3", 1'b1, 5'd3, 32'h33);
        drive(1, 5'd7, 32'h22, 1, 5'd8, 32'h88); tick();
        wr("waw.alu7", 1'b1, 5'd7, 32'h22);
        chk("waw.pending", 32'(pending), 32'd2);
        drive(0, 0, 0, 0, 0, 0); tick();
        wr("waw.killed_pop", 1'b0, 5'd0, 32'd0);
        chk("waw.pending2", 32'(pending), 32'd1);
        tick();
        wr("waw.ld8", 1'b1, 5'd8, 32'h88);
        chk("waw.pending3", 32'(pending), 32'd0);

        // Same-cycle kill: load and ALU to rd 9 together
        drive(1, 5'd9, 32'h22, 1, 5'd9, 32'h99); tick();
        wr("same.alu9", 1'b1, 5'd9, 32'h22);
        chk("same.pending", 32'(pending), 32'd1);
        drive(0, 0, 0, 0, 0, 0); tick();
        wr("same.dropped", 1'b0, 5'd0, 32'd0);
        chk("same.pending2", 32'(pending), 32'd0);

        // x0 load, then simultaneous push and pop
        drive(0, 0, 0, 1, 5'd0, 32'h77); tick();
        chk("x0.pending", 32'(pending), 32'd1);
        drive(0, 0, 0, 1, 5'd12, 32'hC); tick();
        wr("x0.pop", 1'b0, 5'd0, 32'd0);
        chk("pushpop.pending", 32'(pending), 32'd1);
        drive(0, 0, 0, 0, 0, 0); tick();
        wr("pushpop.ld12", 1'b1, 5'd12, 32'hC);
        chk("pushpop.pending2", 32'(pending), 32'd0);

`ifdef WB_ANTISTARVE_EN
        // One load waits behind a permanently busy ALU
        drive(1, 5'd20, 32'h77, 1, 5'd21, 32'h55); tick();
        drive(1, 5'd20, 32'h77, 0, 0, 0);
        for (int w = 1; w <= 8; w++) begin
            chk("starve.no_stall", 32'(alu_stall), 32'd0);
            tick();
            wr("starve.alu", 1'b1, 5'd20, 32'h77);
        end
        chk("starve.stall", 32'(alu_stall), 32'd1);
        tick();
        wr("starve.load", 1'b1, 5'd21, 32'h55);
        chk("starve.pending", 32'(pending), 32'd0);
        chk("starve.released", 32'(alu_stall), 32'd0);
        tick();
        wr("starve.held_alu", 1'b1, 5'd20, 32'h77);
        drive(0, 0, 0, 0, 0, 0); tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Write-side front end of the 32x32 register file. Merges two result producers into the single write port (regWrite/rd/write_data), one write per cycle:
  - ALU: fixed latency, highest priority.
  - Load unit: variable latency, valid/ready handshake.
- Load results are buffered in a small FIFO and drained when the ALU is not writing.
- Write-after-write order is preserved by killing queued stale load writes.

Parameters:
- DEPTH, 4, load FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 8, cycles the FIFO head may wait before the ALU is stalled (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_stall  out  1  ALU result not consumed this cycle; upstream holds it (constant 0 without the optional feature)
- ld_valid  in  1  load result offered
- ld_ready  out  1  FIFO can accept a load result
- ld_rd  in  5  load destination register
- ld_data  in  32  load data
- regWrite  out  1  write enable to the register file
- rd  out  5  write address
- write_data  out  32  write data
- pending  out  $clog2(DEPTH)+1  number of FIFO entries, including killed entries

Behaviour:
- Reset (async, rst_n=0):
  - regWrite=0, rd=0, write_data=0, pending=0, alu_stall=0.
  - FIFO pointers cleared; all kill bits cleared; starve counter=0.
  - Reset mid-operation discards all queued loads.
  - ld_ready=0 while rst_n=0.
- Latency:
  - Output registers are updated one clock after the selecting event.
  - regWrite is high for exactly one cycle per committed write.
- Load handshake:
  - ld_ready = (pending < DEPTH), computed from registered state only.
  - A pop in the same cycle does not make a full FIFO ready.
  - A transfer occurs when ld_valid && ld_ready.
  - ld_rd and ld_data are enqueued unchanged.
- Selection, evaluated each cycle:
  - (1) ALU consumed: alu_valid && !alu_stall. Output = alu_rd/alu_data.
  - (2) Otherwise, FIFO non-empty: pop the head. If the head is live, output = head rd/data. If the head is killed, pop it and set regWrite=0.
  - (3) Otherwise, regWrite=0.
- x0 handling:
  - Any selected write with rd==0 produces regWrite=0.
  - A FIFO pop still occurs, and an ALU result is still consumed.
- WAW kill rule:
  - When an ALU write to rd=R (R!=0) is consumed, every queued FIFO entry with rd==R is marked killed.
  - A load accepted in the same cycle with ld_rd==R is older than the ALU op and is enqueued already killed.
- Pop by an ALU-idle cycle: at most one pop per cycle.
- Simultaneous push and pop: both happen in the same cycle; pending is unchanged.
- Pointers wrap modulo DEPTH. pending distinguishes full from empty.
- Overflow and underflow are impossible by construction.
  - A push with ld_ready=0 is ignored.
  - No pop occurs when pending==0.

Optional Feature:
- Macro: WB_ANTISTARVE_EN.
- Enabled:
  - The starve counter increments each cycle the FIFO is non-empty and no pop occurs. It clears on any pop or when the FIFO is empty.
  - When counter >= STARVE_LIMIT, alu_stall=1 (combinational from the counter). The head is then popped that cycle, and the counter clears.
  - An ALU result offered during alu_stall is not consumed and causes no kill.
- Disabled:
  - alu_stall is tied to 0. The counter is not instantiated.
  - A continuously busy ALU can starve loads indefinitely; ld_ready deasserts once the FIFO is full.

Test Plan:
- Reset: assert rst_n=0 mid-drain with pending=3 -> regWrite=0, pending=0, ld_ready=0. After release, ld_ready=1 with no writes issued.
- ALU-only: alu_valid with rd=5, data=0xDEADBEEF -> next cycle regWrite=1, rd=5, write_data=0xDEADBEEF. With alu_rd=0 -> regWrite stays 0.
- Fill and drain:
  - Push loads rd=1..4 while the ALU is busy every cycle (feature off) -> pending=4, ld_ready=0.
  - Release the ALU -> writes rd=1,2,3,4 in order on consecutive cycles, then pending=0.
- WAW kill:
  - Queue load rd=7 data=0x11, then an ALU write rd=7 data=0x22 -> a single write rd=7 data=0x22.
  - The killed entry pops with regWrite=0. Entries with other rd are unaffected.
- Same-cycle kill: load rd=9 accepted in the same cycle as an ALU write rd=9 -> only the ALU value 0x22 is written; the load is dropped.
- Anti-starve (WB_ANTISTARVE_EN, STARVE_LIMIT=8):
  - ALU valid every cycle, one load queued -> alu_stall=1 on the 9th waiting cycle and the load is written.
  - The held ALU result is written the following cycle.
